// File: rtl/period_meter.sv
// Measures period and high time of a slow async square wave in system clocks.
// Latency: valid 3 edges after sig_in is sampled high; no backpressure, valid is a one-cycle strobe.
module period_meter #(
  parameter int COUNTER_SIZE  = 24,
  parameter int TIMEOUT_LIMIT = 1000000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    sig_in,
  output logic                    sig_sync,
  output logic [COUNTER_SIZE-1:0] period,
  output logic [COUNTER_SIZE-1:0] high_time,
  output logic                    valid,
  output logic                    timeout
);

  localparam logic [COUNTER_SIZE-1:0] CNT_LAST = COUNTER_SIZE'(TIMEOUT_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, MEASURE, STALLED} state_t;

  state_t                  state;
  logic                    s1;
  logic                    prev;
  logic                    rise;
  logic                    fall;
  logic [COUNTER_SIZE-1:0] cnt;
  logic [COUNTER_SIZE-1:0] cnt_inc;
  logic [COUNTER_SIZE-1:0] hi_pend;

  assign rise    = sig_sync & ~prev;
  assign fall    = ~sig_sync & prev;
  // cnt is capped at CNT_LAST, so this increment can never wrap
  assign cnt_inc = cnt + COUNTER_SIZE'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      s1        <= 1'b0;
      sig_sync  <= 1'b0;
      prev      <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      hi_pend   <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      s1       <= sig_in;
      sig_sync <= s1;
      prev     <= sig_sync;
      valid    <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rise) state <= MEASURE;
        end
        MEASURE: begin
          if (rise) begin
            period    <= cnt_inc;
            high_time <= hi_pend;
            valid     <= 1'b1;
            cnt       <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= STALLED;
            timeout <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
          if (fall) hi_pend <= cnt_inc;
        end
        STALLED: begin
          // the period that ends on this rise began before the stall, so it is discarded
          if (rise) begin
            timeout <= 1'b0;
            cnt     <= '0;
            state   <= MEASURE;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          timeout <= 1'b0;
        end
      endcase
    end
  end

endmodule
